// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, oversampled start/data/parity/stop
// FSM and a single-entry output buffer with valid/ready handshake.
`timescale 1ns/1ps
module uart_rx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_tick,
    input  logic                 rx,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int unsigned TickW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
    localparam logic [2:0]       BitLast  = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    // Line synchronizer; resets to the idle level so reset release never looks like a start.
    logic rx_meta_q;
    logic rx_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s      <= rx_meta_q;
        end
    end

    state_e                 state_q, state_d;
    logic [TickW-1:0]       tick_q, tick_d;
    logic [2:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   rx_prev_q, rx_prev_d;
    logic                   par_en_q, par_en_d;
    logic                   par_odd_q, par_odd_d;
    logic                   par_err_q, par_err_d;
    logic                   frm_err_q, frm_err_d;
    logic                   done_q, done_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            rx_prev_q <= 1'b1;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            rx_prev_q <= rx_prev_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            done_q    <= done_d;
        end
    end

    // rx_prev tracks the line at the previous tick, so an edge between ticks is still seen.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        rx_prev_d = rx_prev_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        done_d    = 1'b0;

        if (rx_tick) begin
            rx_prev_d = rx_s;
            case (state_q)
                StIdle: begin
                    if (!rx_s && rx_prev_q) begin
                        tick_d  = '0;
                        state_d = StStart;
                    end
                end
                StStart: begin
                    if (tick_q == TickMid) begin
                        tick_d = '0;
                        if (rx_s) begin
                            state_d = StIdle;
                        end else begin
                            bit_d     = '0;
                            par_en_d  = parity_en;
                            par_odd_d = parity_odd;
                            par_err_d = 1'b0;
                            state_d   = StData;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                StData: begin
                    if (tick_q == TickLast) begin
                        tick_d  = '0;
                        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                        if (bit_q == BitLast) begin
                            bit_d   = '0;
                            state_d = par_en_q ? StParity : StStop;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                StParity: begin
                    if (tick_q == TickLast) begin
                        tick_d    = '0;
                        par_err_d = (rx_s != ((^shreg_q) ^ par_odd_q));
                        state_d   = StStop;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                StStop: begin
                    if (tick_q == TickLast) begin
                        tick_d    = '0;
                        frm_err_d = ~rx_s;
                        done_d    = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: begin
                    tick_d  = '0;
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Output buffer: a same-cycle handshake frees the slot before the new frame lands.
    logic [DATA_BITS-1:0] data_out_d;
    logic                 data_valid_d;
    logic                 frame_err_d;
    logic                 parity_err_d;
    logic                 overrun_err_d;

    always_comb begin
        data_out_d    = data_out;
        data_valid_d  = data_valid;
        frame_err_d   = frame_err;
        parity_err_d  = parity_err;
        overrun_err_d = 1'b0;

        if (done_q) begin
            if (!data_valid || data_ready) begin
                data_out_d   = shreg_q;
                data_valid_d = 1'b1;
                frame_err_d  = frm_err_q;
                parity_err_d = par_en_q & par_err_q;
            end else begin
                overrun_err_d = 1'b1;
            end
        end else if (data_valid && data_ready) begin
            data_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            data_out    <= data_out_d;
            data_valid  <= data_valid_d;
            frame_err   <= frame_err_d;
            parity_err  <= parity_err_d;
            overrun_err <= overrun_err_d;
        end
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: rx_tick every 4 clk, 16 ticks per bit (64 clk per bit).
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BitClks = 64;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic       rx_tick    = 1'b0;
    logic       rx         = 1'b1;
    logic       parity_en  = 1'b0;
    logic       parity_odd = 1'b0;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun_err;
    logic       busy;

    int         checks   = 0;
    int         failures = 0;
    int         ovr_cnt  = 0;
    int         ovr_base;
    logic [1:0] div      = 2'd0;
    logic       acked;
    logic       seen_busy;
    logic       seen_valid;

    uart_rx #(
        .DATA_BITS (8),
        .OVERSAMPLE(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_tick    (rx_tick),
        .rx         (rx),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun_err(overrun_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        div     = div + 2'd1;
        rx_tick = (div == 2'd0);
    end

    always @(negedge clk) begin
        if (overrun_err === 1'b1) ovr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BitClks) @(negedge clk);
    endtask

    // Ends with rx left at the stop level; optionally pulses data_ready in the completion cycle.
    task automatic send_frame(input logic [7:0] d, input logic use_par, input logic par_bit,
                              input logic stop_bit, input logic ack_at_done, output logic got_ack);
        got_ack = 1'b0;
        rx = 1'b1;
        repeat (8) @(negedge clk);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (use_par) send_bit(par_bit);
        rx = stop_bit;
        for (int i = 0; i < BitClks; i++) begin
            @(negedge clk);
            if (ack_at_done && !got_ack && !busy) begin
                data_ready = 1'b1;
                got_ack    = 1'b1;
            end else if (ack_at_done) begin
                data_ready = 1'b0;
            end
        end
    endtask

    task automatic ack();
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("rst_data_out", data_out, 8'h00);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_parity_err", parity_err, 1'b0);
        check("rst_overrun_err", overrun_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b1;
        repeat (8) @(negedge clk);

        // Basic 8N1 frame and handshake
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, acked);
        check("a5_data", data_out, 8'hA5);
        check("a5_valid", data_valid, 1'b1);
        check("a5_frame_err", frame_err, 1'b0);
        check("a5_parity_err", parity_err, 1'b0);
        check("a5_busy", busy, 1'b0);
        ack();
        check("a5_valid_after_ack", data_valid, 1'b0);
        check("a5_data_hold", data_out, 8'hA5);

        // Even parity: 0x03 has even weight, so a correct parity bit is 0
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, acked);
        check("par_bad_err", parity_err, 1'b1);
        check("par_bad_data", data_out, 8'h03);
        check("par_bad_valid", data_valid, 1'b1);
        ack();
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b0, acked);
        check("par_good_err", parity_err, 1'b0);
        check("par_good_valid", data_valid, 1'b1);
        ack();
        parity_odd = 1'b1;
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, acked);
        check("par_odd_good_err", parity_err, 1'b0);
        ack();
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, acked);
        check("par_odd_bad_err", parity_err, 1'b1);
        check("par_odd_bad_data", data_out, 8'h07);
        ack();
        parity_en  = 1'b0;
        parity_odd = 1'b0;

        // Framing error, then a stuck-low line must not start a new frame
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, acked);
        check("ferr_flag", frame_err, 1'b1);
        check("ferr_data", data_out, 8'h55);
        check("ferr_valid", data_valid, 1'b1);
        ack();
        seen_busy  = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 20 * BitClks; i++) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
            if (data_valid) seen_valid = 1'b1;
        end
        check("stuck_low_busy", seen_busy, 1'b0);
        check("stuck_low_valid", seen_valid, 1'b0);
        send_bit(1'b1);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, acked);
        check("after_ferr_data", data_out, 8'h5A);
        check("after_ferr_frame_err", frame_err, 1'b0);
        ack();

        // False start: 6 ticks low then high
        rx = 1'b0;
        repeat (20) @(negedge clk);
        check("false_start_busy_hi", busy, 1'b1);
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (BitClks) @(negedge clk);
        check("false_start_busy_lo", busy, 1'b0);
        check("false_start_valid", data_valid, 1'b0);

        // Overrun: second frame dropped while the first is still held
        ovr_base = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, acked);
        check("ovr_first_data", data_out, 8'h11);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, acked);
        check("ovr_held_data", data_out, 8'h11);
        check("ovr_held_valid", data_valid, 1'b1);
        check("ovr_pulse_count", ovr_cnt - ovr_base, 1);
        check("ovr_pulse_ended", overrun_err, 1'b0);
        ack();
        check("ovr_valid_after_ack", data_valid, 1'b0);

        // Handshake in the completion cycle lets the new frame in without overrun
        ovr_base = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, acked);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b1, acked);
        data_ready = 1'b0;
        check("same_cycle_ack_done", acked, 1'b1);
        check("same_cycle_data", data_out, 8'h22);
        check("same_cycle_valid", data_valid, 1'b1);
        check("same_cycle_no_ovr", ovr_cnt - ovr_base, 0);
        ack();

        // Asynchronous reset during data bit 4, with a frame held in the buffer
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, acked);
        check("pre_rst_valid", data_valid, 1'b1);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0 ^ ((8'h3C >> i) & 1));
        rx = 1'b1;
        repeat (32) @(negedge clk);
        check("pre_rst_busy", busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_valid", data_valid, 1'b0);
        check("async_rst_data", data_out, 8'h00);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_frame_err", frame_err, 1'b0);
        check("async_rst_parity_err", parity_err, 1'b0);
        check("async_rst_overrun", overrun_err, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (BitClks) @(negedge clk);
        check("post_rst_idle", busy, 1'b0);
        check("post_rst_no_frame", data_valid, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, acked);
        check("post_rst_data", data_out, 8'h3C);
        check("post_rst_valid", data_valid, 1'b1);
        check("post_rst_frame_err", frame_err, 1'b0);
        ack();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
